// File: rtl/skew_sr_pkg.sv
// skew_sr_pkg: shared constants and lane-depth helpers for skew_sr_bank.
// Optional feature macro: SKEW_SR_REVERSE_EN mirrors the lane depths so the
// last lane is the shortest (output de-skew).
package skew_sr_pkg;

    localparam int DEFAULT_WIDTH = 19;

    // Number of register stages in lane i.
    function automatic int lane_depth(input int i, input int channels, input int base_delay);
`ifdef SKEW_SR_REVERSE_EN
        return base_delay + (channels - 1 - i);
`else
        return base_delay + i;
`endif
    endfunction

    // Storage summed over all lanes; identical for both depth orderings.
    function automatic int total_stages(input int channels, input int base_delay);
        return channels * base_delay + (channels * (channels - 1)) / 2;
    endfunction

endpackage

// File: rtl/skew_sr_lane.sv
// skew_sr_lane: one DEPTH-stage shift lane with a valid bit per stage.
// DEPTH = 0 degenerates to a combinational pass-through.
module skew_sr_lane
    import skew_sr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy
);

    generate
        if (DEPTH == 0) begin : g_wire
            // No storage: the word only counts as valid when it would have been accepted.
            assign dout       = din;
            assign dout_valid = in_valid & en & ~flush;
            assign busy       = 1'b0;

            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst_n;
        end else begin : g_chain
            logic [WIDTH-1:0] r_data [DEPTH];
            logic [DEPTH-1:0] r_valid;

            // Shift chain: flush beats enable, enable beats hold.
            // NOTE: the data stages are reset as well as the valid bits so that dout reads 0,
            // not stale contents, after reset or flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
                    r_valid <= '0;
                end else if (flush) begin
                    for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
                    r_valid <= '0;
                end else if (en) begin
                    r_data[0]  <= din;
                    r_valid[0] <= in_valid;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_data[k]  <= r_data[k-1];
                        r_valid[k] <= r_valid[k-1];
                    end
                end
            end

            assign dout       = r_data[DEPTH-1];
            assign dout_valid = r_valid[DEPTH-1];
            assign busy       = |r_valid;
        end
    endgenerate

endmodule

// File: rtl/skew_sr_bank.sv
// skew_sr_bank: CHANNELS skew lanes with triangular depths for the systolic
// MAC array. Lane i depth = BASE_DELAY + i, or mirrored when the optional
// macro SKEW_SR_REVERSE_EN is defined.
module skew_sr_bank
    import skew_sr_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int CHANNELS   = 8,
    parameter int BASE_DELAY = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       dout_valid,
    output logic                      busy
);

    logic [CHANNELS-1:0] w_lane_busy;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
            localparam int LANE_DEPTH = lane_depth(i, CHANNELS, BASE_DELAY);

            skew_sr_lane #(
                .WIDTH (WIDTH),
                .DEPTH (LANE_DEPTH)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (en),
                .flush      (flush),
                .in_valid   (in_valid),
                .din        (din[i*WIDTH +: WIDTH]),
                .dout       (dout[i*WIDTH +: WIDTH]),
                .dout_valid (dout_valid[i]),
                .busy       (w_lane_busy[i])
            );
        end
    endgenerate

    assign busy = |w_lane_busy;

endmodule

// File: tb/tb_skew_sr_bank.sv
// tb_skew_sr_bank: self-checking bench for skew_sr_bank (WIDTH=19, CHANNELS=8).
// With SKEW_SR_REVERSE_EN defined the bench builds BASE_DELAY=1 and mirrored depths.
module tb_skew_sr_bank;
    import skew_sr_pkg::*;

    localparam int W  = 19;
    localparam int CH = 8;
`ifdef SKEW_SR_REVERSE_EN
    localparam int BASE = 1;
`else
    localparam int BASE = 0;
`endif
    localparam int DW = W * CH;

    typedef logic [DW-1:0] bus_t;
    typedef struct {
        logic v;
        bus_t d;
    } word_t;

    typedef struct {
        logic          e;
        logic          f;
        logic          v;
        bus_t          d;
        logic [CH-1:0] exp_dv;
        logic          exp_busy;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic          in_valid;
    bus_t          din;
    bus_t          dout;
    logic [CH-1:0] dout_valid;
    logic          busy;

    skew_sr_bank #(.WIDTH(W), .CHANNELS(CH), .BASE_DELAY(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .in_valid   (in_valid),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    max_d;
    int    long_lane;
    word_t hist[$];   // words accepted on enabled edges, newest last

    // Independent statement of the depth rule.
    function automatic int ref_depth(input int i);
`ifdef SKEW_SR_REVERSE_EN
        return BASE + (CH - 1 - i);
`else
        return BASE + i;
`endif
    endfunction

    task automatic check(input string name, input bus_t act, input bus_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane i shows the word accepted D(i) enabled edges ago.
    task automatic model_outputs(output bus_t e_dout, output logic [CH-1:0] e_dv, output logic e_busy);
        e_dout = '0;
        e_dv   = '0;
        e_busy = 1'b0;
        for (int i = 0; i < CH; i++) begin
            int d = ref_depth(i);
            if (d == 0) begin
                e_dout[i*W +: W] = din[i*W +: W];
                e_dv[i]          = in_valid & en & ~flush;
            end else if (hist.size() >= d) begin
                e_dout[i*W +: W] = hist[hist.size()-d].d[i*W +: W];
                e_dv[i]          = hist[hist.size()-d].v;
            end
        end
        foreach (hist[k]) if (hist[k].v) e_busy = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        bus_t          e_dout;
        logic [CH-1:0] e_dv;
        logic          e_busy;
        model_outputs(e_dout, e_dv, e_busy);
        check({tag, "_dout"}, dout, e_dout);
        check({tag, "_dv"}, bus_t'(dout_valid), bus_t'(e_dv));
        check({tag, "_busy"}, bus_t'(busy), bus_t'(e_busy));
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input bus_t d, input string tag);
        @(negedge clk);
        en       = e;
        flush    = f;
        in_valid = v;
        din      = d;
        #1;
        check_outputs(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (flush) begin
                hist.delete();
            end else if (en) begin
                hist.push_back('{v: in_valid, d: din});
                while (hist.size() > max_d) void'(hist.pop_front());
            end
        end
    endtask

    function automatic bus_t all_lanes(input int val);
        bus_t r;
        for (int i = 0; i < CH; i++) r[i*W +: W] = W'(val);
        return r;
    endfunction

    function automatic bus_t lane_code();
        bus_t r;
        for (int i = 0; i < CH; i++) r[i*W +: W] = W'(32'h100 + i);
        return r;
    endfunction

    function automatic bus_t rand_bus();
        bus_t r;
        for (int i = 0; i < CH; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    initial begin
        vec_t tbl[10];
        int   seen[CH];
        int   n_vec;
        int   sum;

        max_d = 0;
        long_lane = 0;
        for (int i = 0; i < CH; i++) begin
            if (ref_depth(i) > max_d) begin
                max_d = ref_depth(i);
                long_lane = i;
            end
        end

        // Reset state
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; din = '0;
        #12;
        check_outputs("reset");
        check("reset_busy", bus_t'(busy), '0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        sum = 0;
        for (int i = 0; i < CH; i++) sum += ref_depth(i);
        check("total_stages", bus_t'(total_stages(CH, BASE)), bus_t'(sum));

        // Latency table: one word at cycle 0, lane i valid exactly in cycle D(i)
        n_vec = max_d + 2;
        for (int c = 0; c < n_vec; c++) begin
            tbl[c].e        = 1'b1;
            tbl[c].f        = 1'b0;
            tbl[c].v        = (c == 0);
            tbl[c].d        = (c == 0) ? lane_code() : '0;
            tbl[c].exp_busy = (c >= 1) && (c <= max_d);
            for (int i = 0; i < CH; i++) tbl[c].exp_dv[i] = (ref_depth(i) == c);
        end
        for (int c = 0; c < n_vec; c++) begin
            drive(tbl[c].e, tbl[c].f, tbl[c].v, tbl[c].d, "lat");
            check($sformatf("lat_tbl_dv_c%0d", c), bus_t'(dout_valid), bus_t'(tbl[c].exp_dv));
            check($sformatf("lat_tbl_busy_c%0d", c), bus_t'(busy), bus_t'(tbl[c].exp_busy));
            for (int i = 0; i < CH; i++)
                if (tbl[c].exp_dv[i])
                    check($sformatf("lat_tbl_data_l%0d", i), bus_t'(dout[i*W +: W]), bus_t'(32'h100 + i));
            tick();
        end

        // Stall: en=0 in cycles 2-4, every lane emits its word exactly once
        for (int i = 0; i < CH; i++) seen[i] = 0;
        for (int c = 0; c <= max_d + 5; c++) begin
            logic e;
            e = !(c >= 2 && c <= 4);
            drive(e, 1'b0, c == 0, (c == 0) ? lane_code() : '0, "stall");
            if (c == max_d + 2) check("stall_long_early", bus_t'(dout_valid[long_lane]), '0);
            if (c == max_d + 3) begin
                check("stall_long_valid", bus_t'(dout_valid[long_lane]), bus_t'(1));
                check("stall_long_data", bus_t'(dout[long_lane*W +: W]), bus_t'(32'h100 + long_lane));
            end
            if (e) for (int i = 0; i < CH; i++) if (dout_valid[i]) seen[i]++;
            tick();
        end
        for (int i = 0; i < CH; i++) check($sformatf("stall_once_l%0d", i), bus_t'(seen[i]), bus_t'(1));

        // Streaming: ten back-to-back words, longest lane emits 0..9 without gaps
        for (int c = 0; c <= max_d + 10; c++) begin
            drive(1'b1, 1'b0, c < 10, (c < 10) ? all_lanes(c) : '0, "stream");
            if (c >= max_d && c < max_d + 10) begin
                check("stream_long_valid", bus_t'(dout_valid[long_lane]), bus_t'(1));
                check("stream_long_data", bus_t'(dout[long_lane*W +: W]), bus_t'(c - max_d));
            end
            if (c == max_d + 10) check("stream_long_end", bus_t'(dout_valid[long_lane]), '0);
            tick();
        end

        // Flush at cycle 3 together with a valid word
        for (int c = 0; c <= max_d + 5; c++) begin
            drive(1'b1, c == 3, c == 0 || c == 3,
                  (c == 0) ? lane_code() : ((c == 3) ? all_lanes(32'h7ff) : '0), "flush");
            if (c >= 4) begin
                check("flush_dv", bus_t'(dout_valid), '0);
                check("flush_busy", bus_t'(busy), '0);
            end
            tick();
        end

        // Asynchronous reset in the middle of cycle 4
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, c == 0, (c == 0) ? lane_code() : '0, "rstmid");
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, "rstmid");
        #2 rst_n = 1'b0;
        #1;
        hist.delete();
        check_outputs("rst_async");
        check("rst_async_dv", bus_t'(dout_valid), '0);
        check("rst_async_busy", bus_t'(busy), '0);
        tick();
        #2 rst_n = 1'b1;
        for (int c = 0; c <= max_d + 1; c++) begin
            drive(1'b1, 1'b0, c == 0, (c == 0) ? lane_code() : '0, "postrst");
            if (c == max_d) check("postrst_long_valid", bus_t'(dout_valid[long_lane]), bus_t'(1));
            if (c == max_d - 1 && max_d > 0) check("postrst_long_early", bus_t'(dout_valid[long_lane]), '0);
            tick();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  1'($urandom), rand_bus(), "rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skew_sr_bank.md
Name: skew_sr_bank

Overview:
Parametrised multi-channel skew shift-register bank for the systolic MAC array. Each channel is a lane of WIDTH-bit registers whose depth grows with channel index, producing the diagonal (triangular) timing skew the array needs on its inputs or outputs. It adds a shift enable, per-lane valid tracking, synchronous flush and a busy flag. One instance replaces a full set of fixed-depth per-row shift registers.

Parameters:
WIDTH, 19, data bits per channel
CHANNELS, 8, number of lanes (>=1)
BASE_DELAY, 0, extra stages added to every lane; lane i depth D(i) = BASE_DELAY + i

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
en  input  1  shift enable; all lanes advance one stage when 1
flush  input  1  synchronous clear of all stages and valid bits
in_valid  input  1  qualifies din for the current cycle, shared by all lanes
din  input  CHANNELS*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
dout  output  CHANNELS*WIDTH  lane i output, same packing
dout_valid  output  CHANNELS  valid of each lane output
busy  output  1  1 while any registered stage holds a valid word

Behaviour:
- Reset (rst_n=0, async): every stage data=0, every valid=0. Registered-lane dout=0, dout_valid=0, busy=0. Release is synchronous to clk; the first shift is on the first rising edge with rst_n=1.
- Lane i holds D(i) stages s0..s(D-1). dout(i) = s(D-1) data; dout_valid(i) = s(D-1) valid.
- D(i)=0 (lane 0 with BASE_DELAY=0): pure wire. dout(i)=din slice; dout_valid(i) = in_valid & en & ~flush.
- Priority per rising edge: flush > en > hold.
  - flush=1: all stage data and valid bits go to 0, regardless of en. A word presented that cycle is discarded.
  - flush=0, en=1: s0 <= {in_valid, din slice}; s(k) <= s(k-1). Data shifts whether or not valid is set; valid is sideband only.
  - flush=0, en=0: all stages hold. Inputs are ignored.
- Latency: a word accepted at edge t appears on lane i after D(i) enabled edges. With en always 1, lane i output is valid in cycle t+D(i). Stalls (en=0) stretch latency 1:1.
- busy = OR of all registered valid bits. A lane with D=0 never contributes.
- Back-to-back words stream one per enabled cycle with no bubbles. Total storage is CHANNELS*BASE_DELAY + CHANNELS*(CHANNELS-1)/2 stages.
- Reset mid-operation: all in-flight words are lost and no partial output appears. Flush mid-operation behaves the same, but synchronously.

Optional Feature:
SKEW_SR_REVERSE_EN
- Defined: depths are mirrored, D(i) = BASE_DELAY + (CHANNELS-1-i). Used for output de-skew, so the last lane becomes the shortest.
- Undefined: D(i) = BASE_DELAY + i.
- All other behaviour is identical in both cases.

Decomposition:
- Package skew_sr_pkg holds:
  - function lane_depth(i, CHANNELS, BASE_DELAY), honouring the macro;
  - function total_stages;
  - a default WIDTH constant (19).
- One sub-module, skew_sr_lane (params WIDTH, DEPTH). It contains a DEPTH-stage register chain with a valid bit per stage, en, flush, rst_n and a busy-contribution output. DEPTH=0 generates a wire.
- The top generates CHANNELS lanes and ORs their busy bits.

Test Plan:
- Latency: WIDTH=19, CHANNELS=8, en=1. Single cycle with in_valid=1 and lane i = 0x100+i at edge 0 -> lane i shows 0x100+i with dout_valid(i)=1 exactly at cycle i (lane 0 in cycle 0, lane 7 in cycle 7). busy falls after cycle 7.
- Stall: inject as above, then drive en=0 for cycles 2-4 -> lanes 0-2 unchanged in timing, lane 7 valid at cycle 10, values intact. No valid is duplicated or dropped.
- Streaming: in_valid=1 for 10 consecutive cycles with lane data = cycle count -> lane 7 outputs 0..9 in cycles 7..16 with no gaps.
- Flush: inject at cycle 0, assert flush at cycle 3 together with in_valid=1 -> all dout_valid=0 and busy=0 from cycle 4. The cycle-3 word never emerges.
- Reset mid-flight: pull rst_n low asynchronously mid-cycle at cycle 4 -> dout=0, dout_valid=0 and busy=0 immediately. After release, a new word has clean latency.
- Macro: compile with SKEW_SR_REVERSE_EN and BASE_DELAY=1 -> lane 0 latency 8, lane 7 latency 1, total_stages=36.
